carry_bypass_adder: RTL and testbench
=====================================

# carry_bypass_adder

32-bit unsigned/two's-complement adder with carry-in and carry-out, built from fixed-size ripple-carry blocks with per-block carry-bypass (skip) multiplexers. The adder itself is combinational; `sum` and `cout` are captured in an output register, so the block presents a registered, one-cycle-latency arithmetic result. It serves as the carry-bypass datapath element in the adders/multipliers chip, alongside the other adder variants.

## Interface
- `WIDTH`, default 32: operand and sum width; must be a multiple of `BLOCK`.
- `BLOCK`, default 4: bits per ripple/bypass block (8 blocks at defaults).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry into bit 0.
- `sum` output WIDTH: registered (a + b + cin) mod 2^WIDTH.
- `cout` output 1: registered carry out of bit WIDTH-1.

## Operation
- Per bit: p_i = a_i ^ b_i, g_i = a_i & b_i, s_i = p_i ^ c_i, c_{i+1} = g_i | (p_i & c_i).
- Each block ripples its carry internally from its block carry-in.
- Block propagate P = AND of the block's BLOCK p_i bits.
- Block carry-out = P ? block carry-in : internal ripple carry-out (bypass mux).
- Block 0 carry-in = `cin`; block k carry-in = block k-1 carry-out; `cout` = last block carry-out.
- The result is bit-exact to {cout, sum} = a + b + cin as a (WIDTH+1)-bit unsigned addition; there is no signed overflow output (overflow is not flagged).
- Signed operands need no special handling: cout is the raw unsigned carry (e.g. 5 + (-3) yields cout = 1).

## Timing
- Combinational path: a, b, cin -> adder -> register D inputs; one register stage at the outputs.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on `sum`/`cout` after edge N and hold until the next edge.
- Throughput: one new operation per cycle; no handshake, no valid signal.
- Reset: at a rising edge with `rst_n` = 0, `sum` <= 0 and `cout` <= 0. Reset takes precedence over the sampled inputs.
- Release: the first edge with `rst_n` = 1 captures the current inputs.
- Reset asserted mid-stream: the in-flight result is discarded, and outputs read 0 after that edge.
- No X-propagation from reset; outputs are defined from the first reset edge onward.

## Structure
- Shared package: default `WIDTH` (32) and `BLOCK` (4) constants. The package holds no typedefs.
- One sub-module, `carry_bypass_block`: a BLOCK-bit ripple adder with block-propagate and bypass mux. Its ports are a, b, ci, s, co.
- Top level: generate loop instantiating WIDTH/BLOCK blocks, chaining the carries, plus the output register.
- Elaboration check: WIDTH % BLOCK == 0.

## Test plan
- Overflow into MSB: reset, then a=32'h7FFFFFFF, b=32'h00000001, cin=0 -> next cycle sum=32'h80000000, cout=0. This exercises the full bypass chain through the all-propagate blocks.
- Wrap with carry: a=32'h80000000, b=32'hFFFFFFFF, cin=0 -> sum=32'h7FFFFFFF, cout=1.
- Mixed-sign operands with and without cin:
  - a=5, b=32'hFFFFFFFD -> sum=2, cout=1.
  - a=12, b=32'hFFFFFFF8, cin=1 -> sum=5, cout=1.
  - a=32'hFFFFFFF1, b=20 -> sum=5, cout=1.
- Small and negative additions:
  - a=7, b=3 -> sum=10, cout=0.
  - a=32'hFFFFFFFC, b=32'hFFFFFFFA -> sum=32'hFFFFFFF6, cout=1.
  - a=0, b=0, cin=1 -> sum=1, cout=0.
  - a=32'hFFFFFFFF, b=0, cin=1 -> sum=0, cout=1 (full propagate, carry-in bypasses every block).
- Reset and pipeline:
  - Drive a=7, b=3, hold `rst_n`=0 for 2 edges -> sum=0, cout=0.
  - Release reset -> sum=10 one edge later.
  - Back-to-back operands on consecutive cycles each appear exactly 1 cycle later.
- Randomized check: 10k random a, b, cin, including all-propagate patterns per block, compared against a behavioural (WIDTH+1)-bit a+b+cin with 1-cycle delay.

Source files
------------

// File: rtl/carry_bypass_adder_pkg.sv
// Shared defaults for the carry-bypass adder and its ripple/bypass blocks.
package carry_bypass_adder_pkg;

    // Operand and sum width.
    localparam int CBA_WIDTH = 32;

    // Bits per ripple/bypass block.
    localparam int CBA_BLOCK = 4;

endpackage : carry_bypass_adder_pkg

// File: rtl/carry_bypass_block.sv
// One BLOCK-bit ripple-carry slice with a carry-bypass mux on its carry-out.
// When every bit of the slice propagates, the block carry-in is forwarded
// straight to the carry-out instead of waiting for the internal ripple.
module carry_bypass_block
    import carry_bypass_adder_pkg::*;
#(
    parameter int BLOCK = CBA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             blk_p;

    assign p     = a ^ b;
    assign g     = a & b;
    assign blk_p = &p;

    // Ripple the carry bit by bit from the block carry-in.
    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s  = p ^ c[BLOCK-1:0];

    // Bypass: an all-propagate block passes its carry-in through directly.
    assign co = blk_p ? ci : c[BLOCK];

endmodule : carry_bypass_block

// File: rtl/carry_bypass_adder.sv
// Carry-bypass adder: WIDTH/BLOCK ripple blocks chained through their bypass
// carry-outs, with {cout, sum} captured in an output register.
// Handshake: none. There is no valid/ready pair; a new operation is accepted
// on every rising edge and its result is visible after that edge, one cycle
// of latency, until the next edge.
module carry_bypass_adder
    import carry_bypass_adder_pkg::*;
#(
    parameter int WIDTH = CBA_WIDTH,
    parameter int BLOCK = CBA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK;

    // Blocks must tile the operand exactly.
    generate
        if ((WIDTH % BLOCK) != 0) begin : g_bad_block
            $error("carry_bypass_adder: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    // Carry between blocks: carry[k] enters block k, carry[NBLK] is the final carry.
    logic             carry [0:NBLK];
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = cin;

    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            carry_bypass_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a (a[k*BLOCK +: BLOCK]),
                .b (b[k*BLOCK +: BLOCK]),
                .ci(carry[k]),
                .s (sum_d[k*BLOCK +: BLOCK]),
                .co(carry[k+1])
            );
        end
    endgenerate

    assign cout_d = carry[NBLK];

    // Output register; reset wins over the sampled inputs and clears the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : carry_bypass_adder

// File: tb/tb_carry_bypass_adder.sv
// Self-checking bench for carry_bypass_adder: directed corner cases, reset
// behaviour, back-to-back pipelining and randomized operands checked against
// a plain (WIDTH+1)-bit arithmetic reference with one cycle of delay.
module tb_carry_bypass_adder;

    localparam int W   = 32;
    localparam int BLK = 4;
    localparam int NB  = W / BLK;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    logic [W:0] exp_q[$];

    carry_bypass_adder #(
        .WIDTH(W),
        .BLOCK(BLK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: the full (W+1)-bit unsigned sum.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Driver: present an operation just after a falling edge.
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 32'd7;
        b     = 32'd3;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 33'd0) begin
            errors++;
            $display("FAIL reset_hold: got cout=%b sum=%h, required cout=0 sum=00000000", cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sum !== 32'd10 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got cout=%b sum=%h, required cout=0 sum=0000000a", cout, sum);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [9];
        logic [W-1:0] tb [9];
        logic         tc [9];
        logic [W-1:0] es [9];
        logic         ec [9];
        ta[0] = 32'h7FFFFFFF; tb[0] = 32'h00000001; tc[0] = 0; es[0] = 32'h80000000; ec[0] = 0;
        ta[1] = 32'h80000000; tb[1] = 32'hFFFFFFFF; tc[1] = 0; es[1] = 32'h7FFFFFFF; ec[1] = 1;
        ta[2] = 32'd5;        tb[2] = 32'hFFFFFFFD; tc[2] = 0; es[2] = 32'd2;        ec[2] = 1;
        ta[3] = 32'd12;       tb[3] = 32'hFFFFFFF8; tc[3] = 1; es[3] = 32'd5;        ec[3] = 1;
        ta[4] = 32'hFFFFFFF1; tb[4] = 32'd20;       tc[4] = 0; es[4] = 32'd5;        ec[4] = 1;
        ta[5] = 32'd7;        tb[5] = 32'd3;        tc[5] = 0; es[5] = 32'd10;       ec[5] = 0;
        ta[6] = 32'hFFFFFFFC; tb[6] = 32'hFFFFFFFA; tc[6] = 0; es[6] = 32'hFFFFFFF6; ec[6] = 1;
        ta[7] = 32'd0;        tb[7] = 32'd0;        tc[7] = 1; es[7] = 32'd1;        ec[7] = 0;
        ta[8] = 32'hFFFFFFFF; tb[8] = 32'd0;        tc[8] = 1; es[8] = 32'd0;        ec[8] = 1;
        for (int i = 0; i < 9; i++) begin
            drive(ta[i], tb[i], tc[i]);
            @(negedge clk);
            checks++;
            if (sum !== es[i] || cout !== ec[i]) begin
                errors++;
                $display("FAIL directed_%0d: a=%h b=%h cin=%b got cout=%b sum=%h, required cout=%b sum=%h",
                         i, ta[i], tb[i], tc[i], cout, sum, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic c;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== exp) begin
                    errors++;
                    $display("FAIL back_to_back_%0d: got %h, required %h", i, {cout, sum}, exp);
                end
            end
            if (i < 8) begin
                x = W'(i * 32'h1111_1111);
                y = ~W'(i * 32'h0F0F_0F0F) + W'(i);
                c = i[0];
                a = x; b = y; cin = c;
                exp_q.push_back(ref_add(x, y, c));
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(32'h1234_5678, 32'h1111_1111, 1'b1);
        @(negedge clk);
        checks++;
        if (sum !== 32'h2345_678A || cout !== 1'b0) begin
            errors++;
            $display("FAIL midstream_before: got cout=%b sum=%h, required cout=0 sum=2345678a", cout, sum);
        end
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        cin   = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 33'd0) begin
            errors++;
            $display("FAIL midstream_reset: got cout=%b sum=%h, required cout=0 sum=00000000", cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sum !== 32'hFFFF_FFFF || cout !== 1'b1) begin
            errors++;
            $display("FAIL midstream_release: got cout=%b sum=%h, required cout=1 sum=ffffffff", cout, sum);
        end
    endtask

    task automatic test_random(input int n);
        logic [W:0]   exp;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        int           mode;
        exp_q.delete();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== exp) begin
                    errors++;
                    $display("FAIL random_%0d: got %h, required %h", i, {cout, sum}, exp);
                end
            end
            if (i < n) begin
                mode = $urandom_range(0, 3);
                x = $urandom;
                y = $urandom;
                c = 1'($urandom_range(0, 1));
                if (mode == 1) begin
                    for (int k = 0; k < NB; k++) begin
                        if ($urandom_range(0, 1) == 1) y[k*BLK +: BLK] = ~x[k*BLK +: BLK];
                    end
                end else if (mode == 2) begin
                    y = ~x;
                end else if (mode == 3) begin
                    case ($urandom_range(0, 2))
                        0:       y = '0;
                        1:       y = '1;
                        default: y = 32'd1;
                    endcase
                end
                a = x; b = y; cin = c;
                exp_q.push_back(ref_add(x, y, c));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random(10000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_carry_bypass_adder
